// File: rtl/dac_frame_sequencer_if.sv
// dac_frame_sequencer_if: FIFO pop side and DAC sample bus of the frame sequencer
interface dac_frame_sequencer_if #(
    parameter int DW = 24
);
    logic            fifo_empty;
    logic [2*DW-1:0] fifo_rdata;
    logic            fifo_ren;
    logic [DW-1:0]   dout;
    logic            dout_en;
    logic            dout_lr;
    logic            underrun;
    modport master (
        input  fifo_empty, fifo_rdata,
        output fifo_ren, dout, dout_en, dout_lr, underrun
    );
    modport slave (
        output fifo_empty, fifo_rdata,
        input  fifo_ren, dout, dout_en, dout_lr, underrun
    );
endinterface

// File: rtl/dac_frame_sequencer.sv
// dac_frame_sequencer: plays {left,right} FIFO words as L/R DAC slots paced by outclk; DAC_SEQ_UNDERRUN_CNT_EN adds a saturating underrun counter
module dac_frame_sequencer #(
    parameter int DW  = 24,
    parameter int UCW = 8
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 outclk,
`ifdef DAC_SEQ_UNDERRUN_CNT_EN
    input  logic                 underrun_clr,
    output logic [UCW-1:0]       underrun_cnt,
`endif
    dac_frame_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, ALIGN, LEFT, RIGHT, UNDER} state_t;
    state_t          state;
    logic            sync1, sync2, dly;
    logic [2*DW-1:0] hold;
    logic            rise, pop, ur_evt;
    assign rise   = sync2 & ~dly;
    assign pop    = enable & rise & ~bus.fifo_empty & (state == ALIGN || state == UNDER || state == RIGHT);
    assign ur_evt = enable & rise & bus.fifo_empty & (state == RIGHT);
    assign bus.fifo_ren = pop;
    // bring outclk into pclk and keep a delayed copy so each slot edge gives one rise
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) {sync1, sync2, dly} <= '0;
        else        {sync1, sync2, dly} <= {outclk, sync1, sync2};
    end
    // slot sequencer: frames always start on the left half of a freshly popped word
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hold         <= '0;
            bus.dout     <= '0;
            bus.dout_en  <= 1'b0;
            bus.dout_lr  <= 1'b0;
            bus.underrun <= 1'b0;
        end else if (!enable) begin
            state        <= IDLE;
            hold         <= '0;
            bus.dout     <= '0;
            bus.dout_en  <= 1'b0;
            bus.dout_lr  <= 1'b0;
            bus.underrun <= 1'b0;
        end else begin
            bus.underrun <= 1'b0;
            if (pop) hold <= bus.fifo_rdata;
            case (state)
                IDLE: state <= ALIGN;
                ALIGN, UNDER, RIGHT: begin
                    if (pop) begin
                        state       <= LEFT;
                        bus.dout    <= bus.fifo_rdata[2*DW-1:DW];
                        bus.dout_lr <= 1'b1;
                        bus.dout_en <= 1'b1;
                    end else if (ur_evt) begin
                        state        <= UNDER;
                        bus.dout     <= '0;
                        bus.dout_lr  <= 1'b0;
                        bus.dout_en  <= 1'b0;
                        bus.underrun <= 1'b1;
                    end
                end
                LEFT: begin
                    if (rise) begin
                        state       <= RIGHT;
                        bus.dout    <= hold[DW-1:0];
                        bus.dout_lr <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef DAC_SEQ_UNDERRUN_CNT_EN
    // count RIGHT->UNDER events, saturating; a clear beats a same-cycle increment
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n)                         underrun_cnt <= '0;
        else if (underrun_clr)              underrun_cnt <= '0;
        else if (ur_evt && ~&underrun_cnt)  underrun_cnt <= underrun_cnt + 1'b1;
    end
`endif
endmodule
